// File: rtl/rate_detector.sv
// Recovers the rate code of a pulse train by timing pulse-to-pulse intervals
// against four nominal periods; reports RATE/LOCKED after LOCK_COUNT agreeing intervals.
module rate_detector #(
    parameter int unsigned PERIOD1    = 192640,
    parameter int unsigned PERIOD2    = 16113920,
    parameter int unsigned PERIOD3    = 32227840,
    parameter int unsigned TOL        = 1024,
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        PULSE,
    output logic [1:0]  RATE,
    output logic        LOCKED,
    output logic [27:0] PERIOD,
    output logic        ERROR
);

    localparam int unsigned TIMEOUT = PERIOD3 + TOL + 1;
    localparam int unsigned MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LC_M  = MW'(LOCK_COUNT);
    localparam logic [27:0] CNT_MAX = 28'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t         state_q, state_d;
    logic [27:0]    cnt_q, cnt_d;
    logic [1:0]     cand_q, cand_d;
    logic [MW-1:0]  matches_q, matches_d;
    logic [1:0]     rate_q, rate_d;
    logic           locked_q, locked_d;
    logic [27:0]    period_q, period_d;
    logic           error_q, error_d;

    logic [31:0]    p32;
    logic           code_valid;
    logic [1:0]     code;
    logic [MW-1:0]  m_next;

    // Windows are tested in ascending order so the lowest code wins on overlap.
    always_comb begin
        p32        = {4'b0, cnt_q};
        code_valid = 1'b1;
        code       = 2'd0;
        if (cnt_q == 28'd1) begin
            code = 2'd0;
        end else if ((p32 + TOL >= PERIOD1) && (p32 <= PERIOD1 + TOL)) begin
            code = 2'd1;
        end else if ((p32 + TOL >= PERIOD2) && (p32 <= PERIOD2 + TOL)) begin
            code = 2'd2;
        end else if ((p32 + TOL >= PERIOD3) && (p32 <= PERIOD3 + TOL)) begin
            code = 2'd3;
        end else begin
            code_valid = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        matches_d = matches_q;
        rate_d    = rate_q;
        locked_d  = locked_q;
        period_d  = period_q;
        error_d   = 1'b0;
        m_next    = matches_q;
        case (state_q)
            IDLE: begin
                if (PULSE) begin
                    state_d = ACQ;
                    cnt_d   = 28'd1;
                end
            end
            default: begin
                if (PULSE) begin
                    period_d = cnt_q;
                    cnt_d    = 28'd1;
                    if (code_valid) begin
                        if ((code == cand_q) && (matches_q != '0)) begin
                            m_next = (matches_q >= LC_M) ? LC_M : matches_q + 1'b1;
                        end else begin
                            cand_d   = code;
                            m_next   = MW'(1);
                            locked_d = 1'b0;
                            state_d  = ACQ;
                        end
                        matches_d = m_next;
                        if (m_next == LC_M) begin
                            rate_d   = code;
                            locked_d = 1'b1;
                            state_d  = LOCK;
                        end
                    end else begin
                        error_d   = 1'b1;
                        matches_d = '0;
                        locked_d  = 1'b0;
                        state_d   = ACQ;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // No pulse within the slowest window: give up and rearm.
                    state_d   = IDLE;
                    cnt_d     = 28'd0;
                    locked_d  = 1'b0;
                    matches_d = '0;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            matches_q <= '0;
            rate_q    <= '0;
            locked_q  <= 1'b0;
            period_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            matches_q <= matches_d;
            rate_q    <= rate_d;
            locked_q  <= locked_d;
            period_q  <= period_d;
            error_q   <= error_d;
        end
    end

    assign RATE   = rate_q;
    assign LOCKED = locked_q;
    assign PERIOD = period_q;
    assign ERROR  = error_q;

endmodule

// File: doc/rate_detector.md
Name: rate_detector

Overview:
- Receive-side counterpart of the block-speed pulse generator: watches a PULSE train and recovers which of the four rate codes produced it.
- Measures the interval between pulses in CLOCK_50 cycles and matches it against the four nominal periods within a tolerance.
- Reports the recovered RATE and LOCKED once enough consecutive intervals agree.
- Used by the game FSM and self-check logic to confirm the falling-block speed actually in effect.

Parameters:
- PERIOD1, 192640, nominal interval (cycles) for rate code 2'b01
- PERIOD2, 16113920, nominal interval for rate code 2'b10
- PERIOD3, 32227840, nominal interval for rate code 2'b11
- TOL, 1024, allowed absolute deviation (cycles) for codes 1..3; code 0 is exact
- LOCK_COUNT, 2, consecutive matching intervals required to assert LOCKED (>=1)

Ports:
- CLOCK_50  input  1  system clock, all logic on posedge
- RESET  input  1  asynchronous, active-low reset
- PULSE  input  1  pulse train under test, synchronous to CLOCK_50; a cycle with PULSE=1 is one event
- RATE  output  2  recovered rate code
- LOCKED  output  1  high while RATE is confirmed
- PERIOD  output  28  last measured interval in cycles
- ERROR  output  1  one-cycle strobe on a bad interval or timeout

Behaviour:
- Reset (RESET=0, async): state IDLE, cnt=0, cand=0, matches=0, RATE=0, LOCKED=0, PERIOD=0, ERROR=0.
- TIMEOUT = PERIOD3+TOL+1. Parameters must keep windows disjoint; if they overlap, the lowest code wins.
- States: IDLE, ACQ, LOCK.
- IDLE:
  - PULSE=1 -> ACQ, cnt<=1.
  - Otherwise hold. No classification occurs in IDLE.
- ACQ / LOCK, on PULSE=1:
  - Measured interval P=cnt; PERIOD<=P; cnt<=1.
  - Classify P: P==1 -> code 0; |P-PERIODk|<=TOL -> code k; else invalid.
- ACQ / LOCK, on PULSE=0:
  - cnt<=cnt+1.
  - If cnt==TIMEOUT-1 before the increment, instead: state<=IDLE, LOCKED<=0, matches<=0, ERROR<=1 for one cycle, RATE held.
- Valid code c:
  - If c==cand and matches>0: matches<=min(matches+1, LOCK_COUNT).
  - Else: cand<=c, matches<=1; in LOCK this also drops LOCKED<=0 and goes to ACQ.
  - When the updated matches equals LOCK_COUNT: RATE<=cand, LOCKED<=1, state LOCK.
- Invalid code:
  - ERROR<=1 for one cycle, matches<=0, LOCKED<=0, state ACQ, RATE held.
  - cnt restarts at 1; the pulse still serves as the new interval start.
- Latency: all outputs are registered and update on the clock edge that samples the terminating pulse; visible the following cycle.
- Continuous PULSE=1 (rate 0) yields P=1 every cycle. It locks on the LOCK_COUNT-th interval after the first pulse.
- ERROR is never high in IDLE except the timeout strobe cycle. Outside strobes, ERROR=0.
- RESET low mid-measurement: immediate return to reset values; the next pulse is treated as a first pulse.

Test Plan (override PERIOD1=8, PERIOD2=20, PERIOD3=40, TOL=1, LOCK_COUNT=2; TIMEOUT=42):
- Reset: assert RESET=0 mid-run -> RATE=0, LOCKED=0, PERIOD=0, ERROR=0 immediately; first pulse after release gives no classification.
- Rate 1: pulses every 8 cycles -> after 2nd interval (3rd pulse) PERIOD=8, RATE=01, LOCKED=1; intervals 7 and 9 keep the lock; 10 -> ERROR strobe, LOCKED=0.
- Rate 0: PULSE held high 4 cycles from IDLE -> LOCKED=1, RATE=00 after the 3rd high cycle, PERIOD=1.
- Rate change: locked at 20 (RATE=10), then intervals of 40 -> first 40 drops LOCKED with ERROR=0; second 40 gives RATE=11, LOCKED=1.
- Timeout: locked at rate 3, then no pulse -> 42 cycles after last pulse ERROR=1 for one cycle, LOCKED=0, state IDLE, RATE stays 11; next pulse starts a fresh measurement.
- Invalid interval: intervals 8, 15, 8, 8 -> ERROR strobe after 15; LOCKED reasserts with RATE=01 only after the two subsequent 8s.
